// File: rtl/input_unit10_if.sv
// input_unit10_if
//   Link/allocator bundle for one router input unit.
//   master : upstream link + switch allocator side (drives data_in, data_in_valid, ready)
//   slave  : the input unit (drives full, label, data_out, route_err)
//   Signals:
//     data_in       [DATASIZE] flit from upstream link
//     data_in_valid            data_in carries a flit this cycle
//     full                     FIFO holds DEPTH flits; upstream must hold off
//     ready                    allocator consumes head flit this cycle
//     label         [4]        one-hot route request: bit0 L, bit1 N, bit2 E, bit3 S
//     data_out      [DATASIZE] head flit
//     route_err                pulse while an unroutable head is being discarded
interface input_unit10_if #(
    parameter int DATASIZE = 40
);
    logic [DATASIZE-1:0] data_in;
    logic                data_in_valid;
    logic                full;
    logic                ready;
    logic [3:0]          label;
    logic [DATASIZE-1:0] data_out;
    logic                route_err;

    modport master (
        output data_in, data_in_valid, ready,
        input  full, label, data_out, route_err
    );

    modport slave (
        input  data_in, data_in_valid, ready,
        output full, label, data_out, route_err
    );
endinterface

// File: rtl/input_unit10.sv
// input_unit10
//   Router input unit: circular flit FIFO with XY route computation on the
//   head flit. Heads routed west (x < LOCAL_X) have no output port and are
//   dropped automatically, flagged by a route_err pulse.
//   Ports:
//     clk       single clock, rising edge
//     rst       asynchronous, active-high reset (discards stored flits)
//     link      input_unit10_if.slave (data_in/data_in_valid/full,
//               ready/label/data_out/route_err)
//     flit_cnt  [16] saturating count of accepted pushes; present only when
//               INPUT_UNIT_STATS_EN is defined
//   Flit layout: src[39:36] dst[35:32] (y=dst[3:2], x=dst[1:0])
//                timestamp[31:24] data[23:2] type[1:0]
module input_unit10 #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int LOCAL_X  = 0,
    parameter int LOCAL_Y  = 2
) (
    input  logic         clk,
    input  logic         rst,
    input_unit10_if.slave link
`ifdef INPUT_UNIT_STATS_EN
    ,
    output logic [15:0]  flit_cnt
`endif
);

    localparam int         DST_LSB = 32;
    localparam logic [1:0] LX      = 2'(LOCAL_X);
    localparam logic [1:0] LY      = 2'(LOCAL_Y);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DISCARD
    } head_state_t;

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [WIDTH-1:0]    wr_ptr;
    logic [WIDTH-1:0]    rd_ptr;
    logic [WIDTH:0]      count;

    head_state_t         state;
    logic [DATASIZE-1:0] head;
    logic [1:0]          head_x;
    logic [1:0]          head_y;
    logic [3:0]          route_dir;
    logic [3:0]          label;
    logic                route_err;
    logic                full;
    logic                push;
    logic                pop;

    assign full   = (count == (WIDTH+1)'(DEPTH));
    assign push   = link.data_in_valid && !full;
    assign head   = mem[rd_ptr];
    assign head_x = head[DST_LSB+1:DST_LSB];
    assign head_y = head[DST_LSB+3:DST_LSB+2];

    // XY routing: resolve x first, then y.
    always_comb begin
        route_dir = 4'b0000;
        if (head_x > LX)      route_dir = 4'b0100;
        else if (head_y < LY) route_dir = 4'b0010;
        else if (head_y > LY) route_dir = 4'b1000;
        else                  route_dir = 4'b0001;
    end

    // The head state is a pure function of the registered FIFO contents,
    // so the FIFO pointers/count act as the state register; this keeps the
    // empty-to-head latency at one cycle.
    always_comb begin
        state     = IDLE;
        label     = 4'b0000;
        route_err = 1'b0;
        pop       = 1'b0;
        if (count != '0) begin
            state = (head_x < LX) ? DISCARD : ROUTE;
        end
        case (state)
            ROUTE: begin
                label = route_dir;
                pop   = link.ready;
            end
            DISCARD: begin
                route_err = 1'b1;
                pop       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= link.data_in;
    end

`ifdef INPUT_UNIT_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_cnt <= '0;
        end else if (push && (flit_cnt != '1)) begin
            flit_cnt <= flit_cnt + 1'b1;
        end
    end
`endif

    assign link.full      = full;
    assign link.label     = label;
    assign link.data_out  = head;
    assign link.route_err = route_err;

endmodule

// File: tb/tb_input_unit10.sv
module tb_input_unit10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    input_unit10_if #(.DATASIZE(40)) bus_a ();
    input_unit10_if #(.DATASIZE(40)) bus_b ();

`ifdef INPUT_UNIT_STATS_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    input_unit10 #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .LOCAL_X(0), .LOCAL_Y(2)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .link (bus_a.slave)
`ifdef INPUT_UNIT_STATS_EN
        , .flit_cnt (cnt_a)
`endif
    );

    input_unit10 #(.DEPTH(8), .WIDTH(3), .DATASIZE(40), .LOCAL_X(1), .LOCAL_Y(2)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .link (bus_b.slave)
`ifdef INPUT_UNIT_STATS_EN
        , .flit_cnt (cnt_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [39:0] mk(input logic [3:0] dst, input logic [7:0] tag);
        return {4'h5, dst, tag, {14'h0, tag}, 2'b01};
    endfunction

    // Apply inputs for one clock cycle; returns at the following negedge.
    task automatic drive_a(input logic v, input logic [39:0] d, input logic r);
        bus_a.data_in_valid = v;
        bus_a.data_in       = d;
        bus_a.ready         = r;
        @(negedge clk);
    endtask

    task automatic drive_b(input logic v, input logic [39:0] d, input logic r);
        bus_b.data_in_valid = v;
        bus_b.data_in       = d;
        bus_b.ready         = r;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [39:0] exp_q [8];
        logic [3:0]  dsts  [3];
        logic [3:0]  labs  [3];
        logic [39:0] f;

        bus_a.data_in_valid = 1'b0; bus_a.data_in = '0; bus_a.ready = 1'b0;
        bus_b.data_in_valid = 1'b0; bus_b.data_in = '0; bus_b.ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_full",      64'(bus_a.full),      64'd0);
        check("rst_label",     64'(bus_a.label),     64'd0);
        check("rst_route_err", 64'(bus_a.route_err), 64'd0);
        check("rst_label_b",   64'(bus_b.label),     64'd0);
`ifdef INPUT_UNIT_STATS_EN
        check("rst_flit_cnt",  64'(cnt_a),           64'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Single local flit: visible one cycle after push, then popped.
        f = mk(4'b1000, 8'h01);
        drive_a(1'b1, f, 1'b0);
        check("single_label", 64'(bus_a.label),    64'h1);
        check("single_data",  64'(bus_a.data_out), 64'(f));
        drive_a(1'b0, '0, 1'b1);
        check("single_empty", 64'(bus_a.label),    64'h0);

        // Fill to full, drop the ninth, drain in order across the wrap.
        for (int i = 0; i < 8; i++) begin
            exp_q[i] = mk(4'b1000, 8'(8'h10 + i));
            drive_a(1'b1, exp_q[i], 1'b0);
            if (i == 6) check("not_full_at_7", 64'(bus_a.full), 64'd0);
        end
        check("full_after_8", 64'(bus_a.full), 64'd1);
        drive_a(1'b1, mk(4'b1000, 8'hEE), 1'b0);
        check("full_after_drop", 64'(bus_a.full),     64'd1);
        check("head_after_drop", 64'(bus_a.data_out), 64'(exp_q[0]));
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain_data_%0d", i), 64'(bus_a.data_out), 64'(exp_q[i]));
            drive_a(1'b0, '0, 1'b1);
        end
        check("drain_empty_label", 64'(bus_a.label), 64'h0);
        check("drain_empty_full",  64'(bus_a.full),  64'd0);

        // Routing directions with LOCAL=(0,2).
        dsts[0] = 4'b1001; labs[0] = 4'b0100;   // x=1,y=2 -> E
        dsts[1] = 4'b0100; labs[1] = 4'b0010;   // x=0,y=1 -> N
        dsts[2] = 4'b1100; labs[2] = 4'b1000;   // x=0,y=3 -> S
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, mk(dsts[i], 8'(8'h30 + i)), 1'b0);
            check($sformatf("route_label_%0d", i), 64'(bus_a.label), 64'(labs[i]));
            check($sformatf("route_noerr_%0d", i), 64'(bus_a.route_err), 64'd0);
            drive_a(1'b0, '0, 1'b1);
        end
        check("route_empty", 64'(bus_a.label), 64'h0);

        // Full with simultaneous push and ready: pop wins, push lost.
        for (int i = 0; i < 8; i++) begin
            exp_q[i] = mk(4'b1000, 8'(8'h40 + i));
            drive_a(1'b1, exp_q[i], 1'b0);
        end
        check("full_again", 64'(bus_a.full), 64'd1);
        drive_a(1'b1, mk(4'b1000, 8'hAA), 1'b1);
        check("full_pushpop_full", 64'(bus_a.full), 64'd0);
        for (int i = 1; i < 8; i++) begin
            check($sformatf("pushpop_data_%0d", i), 64'(bus_a.data_out), 64'(exp_q[i]));
            drive_a(1'b0, '0, 1'b1);
        end
        check("pushpop_lost", 64'(bus_a.label), 64'h0);

        // Reset mid-stream with 5 stored: immediate clear, then accept.
        for (int i = 0; i < 5; i++) drive_a(1'b1, mk(4'b1000, 8'(8'h50 + i)), 1'b0);
        bus_a.data_in_valid = 1'b0;
        check("pre_rst_label", 64'(bus_a.label), 64'h1);
        rst = 1'b1;
        #1;
        check("mid_rst_label", 64'(bus_a.label), 64'h0);
        check("mid_rst_full",  64'(bus_a.full),  64'd0);
        @(negedge clk);
        rst = 1'b0;
        f = mk(4'b1000, 8'h60);
        drive_a(1'b1, f, 1'b0);
        check("post_rst_label", 64'(bus_a.label),    64'h1);
        check("post_rst_data",  64'(bus_a.data_out), 64'(f));
        drive_a(1'b0, '0, 1'b1);
        check("post_rst_empty", 64'(bus_a.label), 64'h0);

        // LOCAL_X=1: west-bound head discarded without ready.
        drive_b(1'b1, mk(4'b1000, 8'h70), 1'b0);
        check("west_route_err", 64'(bus_b.route_err), 64'd1);
        check("west_label",     64'(bus_b.label),     64'h0);
        f = mk(4'b1001, 8'h71);
        drive_b(1'b1, f, 1'b0);
        check("west_err_cleared", 64'(bus_b.route_err), 64'd0);
        check("west_next_label",  64'(bus_b.label),     64'h1);
        check("west_next_data",   64'(bus_b.data_out),  64'(f));
        drive_b(1'b0, '0, 1'b1);
        check("west_empty", 64'(bus_b.label), 64'h0);

`ifdef INPUT_UNIT_STATS_EN
        // 10 accepted pushes and 1 dropped.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("stats_reset", 64'(cnt_a), 64'd0);
        for (int i = 0; i < 8; i++) drive_a(1'b1, mk(4'b1000, 8'(i)), 1'b0);
        drive_a(1'b1, mk(4'b1000, 8'hFF), 1'b0);
        drive_a(1'b0, '0, 1'b1);
        drive_a(1'b0, '0, 1'b1);
        drive_a(1'b1, mk(4'b1000, 8'h08), 1'b0);
        drive_a(1'b1, mk(4'b1000, 8'h09), 1'b0);
        bus_a.data_in_valid = 1'b0;
        check("stats_flit_cnt", 64'(cnt_a), 64'd10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/input_unit10.md
INPUT_UNIT10 -- requirements
Module: input_unit10

Interface
REQ-001 Parameter DEPTH, default 8: FIFO entries; SHALL be a power of two.
REQ-002 Parameter WIDTH, default 3: pointer width; SHALL equal log2(DEPTH).
REQ-003 Parameter DATASIZE, default 40: flit width, laid out as src[39:36], dst[35:32] (y=dst[3:2], x=dst[1:0]), timestamp[31:24], data[23:2], type[1:0].
REQ-004 Parameter LOCAL_X, default 0: router x coordinate.
REQ-005 Parameter LOCAL_Y, default 2: router y coordinate.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous assert, active-high.
REQ-008 data_in  input  DATASIZE  flit from upstream link.
REQ-009 data_in_valid  input  1  data_in carries a flit this cycle.
REQ-010 full  output  1  FIFO holds DEPTH flits; upstream SHALL NOT send while high.
REQ-011 ready  input  1  switch allocator consumes head flit this cycle.
REQ-012 label  output  4  one-hot route request of head flit: bit0 L, bit1 N, bit2 E, bit3 S; 0000 = no request.
REQ-013 data_out  output  DATASIZE  head flit.
REQ-014 route_err  output  1  one-cycle pulse when an unroutable head flit is discarded.

Function
REQ-015 Circular FIFO: write pointer, read pointer (WIDTH bits, wrap DEPTH-1 -> 0), occupancy count (WIDTH+1 bits).
REQ-016 Push when data_in_valid && !full; a flit offered while full SHALL be dropped and state unchanged.
REQ-017 full = (count == DEPTH), from registered count; push and pop in the same cycle while full: pop occurs, push dropped.
REQ-018 Push and pop in the same cycle while neither empty nor full: count unchanged, both pointers advance.
REQ-019 Latency: a flit pushed in cycle t SHALL appear on data_out/label in cycle t+1 if the FIFO was empty.
REQ-020 data_out is the entry at read pointer, combinational from storage; when empty, label = 0000 and data_out is don't-care.
REQ-021 XY routing on head flit: x>LOCAL_X -> E; x==LOCAL_X and y<LOCAL_Y -> N; x==LOCAL_X and y>LOCAL_Y -> S; x==LOCAL_X and y==LOCAL_Y -> L.
REQ-022 x<LOCAL_X (west, no port) is unroutable: label = 0000; the head is auto-popped on the next rising edge regardless of ready; route_err is high in the cycle the head is presented.
REQ-023 Pop when ready && label != 0000; ready with empty FIFO or unroutable head is ignored.
REQ-024 Two-state head FSM: ROUTE (head valid and routable, waits for ready) and DISCARD (head unroutable, pops in one cycle); IDLE when empty; state derived from head each cycle.

Reset
REQ-025 On rst: pointers=0, count=0, full=0, label=0000, route_err=0; FIFO storage not cleared.
REQ-026 rst asserted mid-operation SHALL discard all stored flits immediately; the first push after rst deasserts is accepted at the next edge.

Configuration
REQ-027 Macro INPUT_UNIT_STATS_EN: when defined, adds output flit_cnt (16 bits), counting accepted pushes, saturating at 16'hFFFF and reset to 0; when undefined, the port and counter do not exist and behaviour is otherwise identical.

Verification
REQ-028 Reset, then push one flit with dst=4'b1000 (y=2, x=0) -> next cycle label=0001, data_out equals flit; ready=1 -> empty, label=0000.
REQ-029 Push 8 flits with ready=0 -> full=1 after 8th; 9th flit dropped; drain with ready=1 returns the 8 flits in order, with pointers wrapping.
REQ-030 Heads with dst x=1,y=2 / x=0,y=1 / x=0,y=3 -> labels 0100 / 0010 / 1000 respectively.
REQ-031 Instance with LOCAL_X=1; push dst x=0 followed by a valid flit -> route_err pulses one cycle, bad flit removed without ready, next head label valid.
REQ-032 Full FIFO, simultaneous push and ready -> count becomes 7, pushed flit lost; rst mid-stream with 5 stored -> label=0000, full=0 immediately.
REQ-033 With INPUT_UNIT_STATS_EN defined, 10 accepted pushes and 1 dropped push -> flit_cnt=10.
